// File: rtl/qll_pkg.sv
// Shared Q5.10 fixed-point definitions for the requantisation datapath.
package qll_pkg;

  localparam int Q_WIDTH   = 16;
  localparam int Q_FRAC    = 10;
  localparam int ACC_WIDTH = 32;

  typedef logic signed [Q_WIDTH-1:0]   q5_10_t;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  localparam q5_10_t Q_MAX = 16'h7FFF;
  localparam q5_10_t Q_MIN = 16'h8000;

endpackage

// File: rtl/requant_fifo.sv
// Synchronous output FIFO for requantised samples.
// A push is accepted when the FIFO has space or is popped in the same cycle.
// Otherwise it is refused and `drop` flags it.
module requant_fifo
  import qll_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop;
  logic             wr_en;

  // Pop only a stored entry; a full FIFO still accepts a push when popped this cycle.
  always_comb begin
    out_valid = (count != '0);
    pop       = out_valid && pop_ready;
    wr_en     = push && ((count != (AW+1)'(DEPTH)) || pop);
    drop      = push && !wr_en;
    out_data  = out_valid ? mem[rd_ptr] : '0;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; stale contents are masked by out_valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/acc_requant.sv
// Accumulator requantisation: add Q5.10 bias, saturate to WIDTH bits, queue in a FIFO.
// Optional macro ACC_REQUANT_RELU_EN clamps negative saturated results to zero.
module acc_requant
  import qll_pkg::*;
#(
  parameter int WIDTH     = qll_pkg::Q_WIDTH,
  parameter int ACC_WIDTH = qll_pkg::ACC_WIDTH,
  parameter int DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [ACC_WIDTH-1:0] acc_in,
  input  logic signed [WIDTH-1:0]     bias,
  input  logic                        clr,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  input  logic                        out_ready,
  output logic                        almost_full,
  output logic                        ovf,
  output logic [7:0]                  drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                      s1_valid;
  logic signed [ACC_WIDTH:0] s1_sum;
  logic                      sign;
  logic                      fits;
  logic [WIDTH-1:0]          sat;
  logic [WIDTH-1:0]          push_data;
  logic [CW-1:0]             count;
  logic                      drop;

  // Stage 1: widen by one bit so the bias add can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else if (clr) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid)
        s1_sum <= {acc_in[ACC_WIDTH-1], acc_in}
                + {{(ACC_WIDTH+1-WIDTH){bias[WIDTH-1]}}, bias};
    end
  end

  // Stage 2: the sum fits when every bit above the output sign matches the sign.
  always_comb begin
    sign = s1_sum[ACC_WIDTH];
    fits = (&s1_sum[ACC_WIDTH:WIDTH-1]) || !(|s1_sum[ACC_WIDTH:WIDTH-1]);
    sat  = fits ? s1_sum[WIDTH-1:0] : {sign, {(WIDTH-1){~sign}}};
`ifdef ACC_REQUANT_RELU_EN
    push_data = sat[WIDTH-1] ? '0 : sat;
`else
    push_data = sat;
`endif
  end

  requant_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (s1_valid),
    .push_data (push_data),
    .pop_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count),
    .drop      (drop)
  );

  // Upstream throttle, raised early enough to cover the two-stage pipeline.
  always_comb begin
    almost_full = (count >= CW'(DEPTH - 2));
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_acc_requant.sv
// Directed self-checking bench for acc_requant (default depth 4, Q5.10).
module tb_acc_requant;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic signed [31:0] acc_in;
  logic signed [15:0] bias;
  logic               clr;
  logic               out_valid;
  logic [15:0]        out_data;
  logic               out_ready;
  logic               almost_full;
  logic               ovf;
  logic [7:0]         drop_cnt;

  int total = 0;
  int bad   = 0;

  acc_requant dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .acc_in      (acc_in),
    .bias        (bias),
    .clr         (clr),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .almost_full (almost_full),
    .ovf         (ovf),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_data"}, {16'd0, out_data}, 32'd0);
    chk({tag, "_af"}, {31'd0, almost_full}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
    chk({tag, "_drop"}, {24'd0, drop_cnt}, 32'd0);
  endtask

  // One isolated transaction with out_ready=1: result appears exactly two edges later.
  task automatic send1(input string tag, input logic [31:0] a, input logic [15:0] b,
                       input logic [15:0] exp);
    in_valid = 1'b1; acc_in = a; bias = b;
    step();
    in_valid = 1'b0;
    chk({tag, "_n1_valid"}, {31'd0, out_valid}, 32'd0);
    step();
    chk({tag, "_n2_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_n2_data"}, {16'd0, out_data}, {16'd0, exp});
    step();
    chk({tag, "_popped"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Queue values with out_ready low, then allow them to land in the FIFO.
  task automatic fill(input int first, input int n);
    out_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1; acc_in = first + k; bias = '0;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
  endtask

  logic [15:0] neg_sat_exp;
  logic [15:0] drain_exp [4];

  initial begin
`ifdef ACC_REQUANT_RELU_EN
    neg_sat_exp = 16'h0000;
`else
    neg_sat_exp = 16'h8000;
`endif
    rst_n = 1'b0; in_valid = 1'b0; acc_in = '0; bias = '0; clr = 1'b0; out_ready = 1'b1;
    #2;
    chk_zero_outputs("reset");
    #20;
    rst_n = 1'b1;
    step();

    // Basic add: 3.0 + 1.0 = 4.0
    send1("basic", 32'h0000_0C00, 16'h0400, 16'h1000);
    // Saturation corners
    send1("sat_pos", 32'h0001_0000, 16'h0000, 16'h7FFF);
    send1("sat_neg", 32'hFFFF_0000, 16'h0000, neg_sat_exp);
    send1("sat_carry", 32'h0000_7FFF, 16'h0001, 16'h7FFF);
    send1("neg_bias", 32'h0000_0400, 16'hF800, neg_sat_exp == 16'h0 ? 16'h0000 : 16'hFC00);

    // Drop accounting: six back-to-back with no consumer
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      in_valid = 1'b1; acc_in = k; bias = '0;
      step();
      if (k == 2) chk("af_one_stored", {31'd0, almost_full}, 32'd0);
      if (k == 3) chk("af_two_stored", {31'd0, almost_full}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    step();
    chk("drop_ovf", {31'd0, ovf}, 32'd1);
    chk("drop_cnt2", {24'd0, drop_cnt}, 32'd2);
    chk("drop_hold_data", {16'd0, out_data}, 32'd1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("drain_valid", {31'd0, out_valid}, 32'd1);
      chk("drain_data", {16'd0, out_data}, k);
      step();
    end
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    chk("drain_af_low", {31'd0, almost_full}, 32'd0);

    // Full FIFO: pop and push in the same cycle
    fill(11, 4);
    in_valid = 1'b1; acc_in = 15; bias = '0;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pp_full_drop", {24'd0, drop_cnt}, 32'd2);
    chk("pp_full_af", {31'd0, almost_full}, 32'd1);
    drain_exp[0] = 16'd12; drain_exp[1] = 16'd13; drain_exp[2] = 16'd14; drain_exp[3] = 16'd15;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("pp_drain_valid", {31'd0, out_valid}, 32'd1);
      chk("pp_drain_data", {16'd0, out_data}, {16'd0, drain_exp[k]});
      step();
    end
    chk("pp_drain_empty", {31'd0, out_valid}, 32'd0);

    // Flush: queued results discarded, in_valid in the clr cycle ignored
    fill(21, 3);
    chk("flush_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("flush_pre_ovf", {31'd0, ovf}, 32'd1);
    clr = 1'b1; in_valid = 1'b1; acc_in = 32'h0000_0100;
    step();
    clr = 1'b0; in_valid = 1'b0;
    chk_zero_outputs("flush");
    out_ready = 1'b1;
    step();
    step();
    chk("flush_discard", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-stream
    fill(31, 6);
    chk("rst_pre_drop", {24'd0, drop_cnt}, 32'd2);
    in_valid = 1'b1; acc_in = 40;
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    in_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    send1("post_rst", 32'h0000_0C00, 16'h0400, 16'h1000);

    // drop_cnt saturation: 310 pushes into a 4-deep FIFO -> 306 drops
    out_ready = 1'b0;
    for (int k = 0; k < 310; k++) begin
      in_valid = 1'b1; acc_in = k; bias = '0;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("drop_sat", {24'd0, drop_cnt}, 32'd255);
    chk("drop_sat_ovf", {31'd0, ovf}, 32'd1);
    chk("drop_sat_head", {16'd0, out_data}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
